beat_sequencer: RTL



---
 rtl/beat_pkg.sv | 13 +
 rtl/beat_ram.sv | 21 ++
 rtl/beat_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/beat_pkg.sv
// Shared definitions for the beat record/playback engine: state encoding
// (also decoded by the HEX display) and the rest note code.
package beat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } beat_state_e;

  localparam int unsigned REST = 0;

endpackage

// File: rtl/beat_ram.sv
// Single-port synchronous beat RAM with one-cycle read latency; no reset so it
// maps onto block RAM.
module beat_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned NOTE_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [NOTE_W-1:0] wdata_i,
  output logic [NOTE_W-1:0] rdata_o
);

  logic [NOTE_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/beat_sequencer.sv
// Record/playback engine: samples the live note into the beat RAM at the tick
// rate while recording and loops the stored recording back during playback.
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int unsigned TICK_DIV = 3125000,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned NOTE_W   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ram_load,
  input  logic              keyboard_record,
  input  logic              rd_load_from,
  input  logic              play_en,
  input  logic [NOTE_W-1:0] note_in,
  output logic [NOTE_W-1:0] note_out,
  output logic [1:0]        state_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [ADDR_W:0]   rec_len,
  output logic              full
);

  localparam int unsigned    CNT_W   = $clog2(TICK_DIV);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [NOTE_W-1:0] REST_N = NOTE_W'(REST);

  beat_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              full_q, full_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [NOTE_W-1:0] hold_q, hold_d;
  logic              rd_vld_q, rd_vld_d;
  logic              tick, stay, we;
  logic [NOTE_W-1:0] ram_rdata;

  beat_ram #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W)) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .addr_i  (addr_q),
    .wdata_i (keyboard_record ? note_in : REST_N),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ram_load)                       state_d = RECORD;
        else if (play_en && (len_q != '0))  state_d = PLAY;
      end
      RECORD: if (!ram_load) state_d = IDLE;
      PLAY: begin
        if (ram_load)      state_d = RECORD;
        else if (!play_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A tick that lands on an exit transition is dropped: only act while staying.
  always_comb begin
    tick     = (cnt_q == CNT_W'(TICK_DIV - 1));
    stay     = (state_d == state_q);
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    len_d    = len_q;
    full_d   = full_q;
    we       = 1'b0;
    rd_vld_d = 1'b0;
    if (!stay) begin
      cnt_d  = '0;
      addr_d = '0;
      if (state_d == RECORD) begin
        len_d  = '0;
        full_d = 1'b0;
      end
    end else if (state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick && (state_q == RECORD) && (len_q < DEPTH_L)) begin
        we     = 1'b1;
        len_d  = len_q + 1'b1;
        full_d = ((len_q + 1'b1) == DEPTH_L);
        if (addr_q != '1) addr_d = addr_q + 1'b1;
      end
      if (tick && (state_q == PLAY)) begin
        rd_vld_d = 1'b1;
        addr_d   = (({1'b0, addr_q} + 1'b1) == len_q) ? '0 : addr_q + 1'b1;
      end
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (state_q != PLAY) hold_d = REST_N;
    else if (rd_vld_q)   hold_d = ram_rdata;

    if ((state_q == RECORD) || rd_load_from) note_d = note_in;
    else if (state_q == PLAY)                note_d = rd_vld_q ? ram_rdata : hold_q;
    else                                     note_d = REST_N;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      full_q   <= 1'b0;
      note_q   <= '0;
      hold_q   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      full_q   <= full_d;
      note_q   <= note_d;
      hold_q   <= hold_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign note_out  = note_q;
  assign state_out = state_q;
  assign addr_out  = addr_q;
  assign rec_len   = len_q;
  assign full      = full_q;

endmodule
